crp16_mmio_bridge: RTL and testbench
====================================

// Module: crp16_mmio_bridge
// PURPOSE
// - Sits between crp16_datapath RAM port B (address_b/data_b/wren_b/q_b) and the dual-port RAM port B.
// - Decodes a 256-word MMIO window and passes every other access to RAM unchanged.
// - The window holds a byte TX FIFO with a valid/ready drain, a free-running 16-bit timer and a drop counter.
// - Preserves the 1-cycle synchronous-read timing the datapath expects on q_b.
// PARAMETERS
// - MMIO_BASE   16'hFF00  window base; only bits [15:8] are compared (window = base..base+0xFF).
// - FIFO_DEPTH  8         TX FIFO entries; legal values 2, 4, 8.
// - FIFO_AW     3         log2(FIFO_DEPTH).
// PORTS
// - clock        in   1   single clock, rising edge.
// - reset        in   1   asynchronous, active-high.
// - dp_address   in   16  from datapath address_b.
// - dp_data      in   16  from datapath data_b.
// - dp_wren      in   1   from datapath wren_b.
// - dp_q         out  16  to datapath q_b.
// - ram_address  out  16  to RAM port B address.
// - ram_data     out  16  to RAM port B data.
// - ram_wren     out  1   to RAM port B write enable.
// - ram_q        in   16  from RAM port B q (valid 1 cycle after address).
// - tx_data      out  8   FIFO head byte.
// - tx_valid     out  1   FIFO non-empty.
// - tx_ready     in   1   consumer accepts head when high with tx_valid.
// BEHAVIOUR
// - Decode: hit = (dp_address[15:8] == MMIO_BASE[15:8]); off = dp_address[7:0].
// - RAM side (combinational):
//   - ram_address = dp_address; ram_data = dp_data; ram_wren = dp_wren & ~hit.
//   - MMIO writes never reach RAM.
// - Read path: 1-cycle latency.
//   - At each edge: hit_r <= hit; mmio_q_r <= read mux for off, using pre-edge state.
//   - dp_q = hit_r ? mmio_q_r : ram_q.
//   - Read-during-write to the same register returns the old value.
// - Register map (offsets):
//   - 0x00 TXDATA  W: push dp_data[7:0]. R: 0x0000.
//   - 0x01 STATUS  R: {8'h00, count[3:0], 2'b00, full, empty}; count = 0..FIFO_DEPTH. W: ignored.
//   - 0x02 TIMER   R: current value. W: load dp_data; that cycle the loaded value replaces the increment.
//   - 0x03 DROPS   R: number of dropped TXDATA pushes, saturating at 0xFFFF. W (any data): clear to 0.
//   - Other offsets: R 0x0000; W ignored.
// - Timer: +1 every cycle; wraps 0xFFFF -> 0x0000.
// - FIFO:
//   - Circular buffer with FIFO_AW-bit read/write pointers and a (FIFO_AW+1)-bit count.
//   - Pointers wrap from FIFO_DEPTH-1 to 0.
//   - tx_valid = (count != 0); tx_data = mem[rd_ptr].
//   - Pop when tx_valid & tx_ready.
//   - Push when dp_wren & hit & off==0 & ~full, where full is evaluated before this cycle's pop. A push while full
//     is dropped even if a pop occurs in the same cycle; DROPS then increments unless it is already 0xFFFF.
//   - Push and pop in the same cycle: count unchanged; both pointers advance.
//   - empty: tx_valid=0, so no pop occurs; tx_ready is ignored.
// - Reset (async, any time, including mid-drain):
//   - Pointers 0, count 0, TIMER 0, DROPS 0, hit_r 0, mmio_q_r 0.
//   - tx_valid=0; dp_q follows ram_q.
//   - FIFO storage contents are not reset.
// - After reset deasserts, the first edge starts normal operation; TIMER reads 0x0000 if sampled at that first edge.
// TESTING
// - RAM passthrough: write 0x1234 to 0x0010, read 0x0010 -> dp_q=0x1234 on the next cycle; ram_wren never high for 0xFF00-0xFFFF.
// - FIFO fill/drain, tx_ready=0: push 0x41..0x48 -> STATUS=0x0082. 9th push -> DROPS=1.
//   Then tx_ready=1 -> bytes 0x41..0x48 emitted in order, then STATUS=0x0001.
// - Full with simultaneous pop: FIFO full, tx_ready=1, push 0x55 -> push dropped, DROPS+1, count=7.
// - Timer: write TIMER=0xFFFE, read on the following cycles -> 0xFFFF, then 0x0000 (wrap).
//   Read-during-write returns the old value.
// - DROPS: force 0x10000 drops -> reads 0xFFFF (saturated); write DROPS -> reads 0x0000.
// - Reset with 3 entries queued and tx_valid=1: assert reset -> tx_valid=0 immediately, STATUS=0x0001, TIMER=0 after release.

Source files
------------

// File: rtl/crp16_mmio_bridge.sv
// crp16_mmio_bridge
//   Sits between the crp16 datapath RAM port B and the dual-port RAM port B.
//   A 256-word window at MMIO_BASE is decoded into a small register file:
//   a byte TX FIFO drained over a valid/ready handshake, a free-running
//   16-bit timer and a saturating count of dropped pushes. Every other access
//   passes straight through to RAM. Reads keep the RAM's 1-cycle latency.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   dp_address/data/wren  datapath port B request
//   dp_q                datapath port B read data (1 cycle after address)
//   ram_address/data/wren  RAM port B request (MMIO writes are suppressed)
//   ram_q               RAM port B read data
//   tx_data, tx_valid   FIFO head byte and non-empty flag
//   tx_ready            consumer accepts the head byte
//
// Register map (offsets inside the window)
//   0x00 TXDATA  W push byte, R 0
//   0x01 STATUS  R {8'h00, count[3:0], 2'b00, full, empty}
//   0x02 TIMER   R value, W load
//   0x03 DROPS   R dropped pushes (saturating), W clear
module crp16_mmio_bridge #(
  parameter logic [15:0] MMIO_BASE  = 16'hFF00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          FIFO_AW    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dp_address,
  input  logic [15:0] dp_data,
  input  logic        dp_wren,
  output logic [15:0] dp_q,
  output logic [15:0] ram_address,
  output logic [15:0] ram_data,
  output logic        ram_wren,
  input  logic [15:0] ram_q,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] LAST_C  = FIFO_AW'(FIFO_DEPTH - 1);

  logic              hit;
  logic [7:0]        off;
  logic              wr_hit;
  logic              full;
  logic              empty;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              drop;
  logic [15:0]       status;
  logic [15:0]       rd_mux;

  logic [FIFO_AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [FIFO_AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [FIFO_AW:0]   count_q,   count_d;
  logic [15:0]        timer_q,   timer_d;
  logic [15:0]        drops_q,   drops_d;
  logic               hit_r_q,   hit_r_d;
  logic [15:0]        mmio_q_r_q, mmio_q_r_d;

  // FIFO storage is deliberately left out of reset.
  logic [7:0] mem_q [FIFO_DEPTH];

  assign hit    = (dp_address[15:8] == MMIO_BASE[15:8]);
  assign off    = dp_address[7:0];
  assign wr_hit = dp_wren & hit;

  // RAM side is pure passthrough except that window writes are blocked.
  assign ram_address = dp_address;
  assign ram_data    = dp_data;
  assign ram_wren    = dp_wren & ~hit;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign tx_valid = ~empty;
  assign tx_data  = mem_q[rd_ptr_q];

  // full is taken before this cycle's pop, so a push into a full FIFO is
  // dropped even when the consumer frees a slot on the same edge.
  assign push_req = wr_hit & (off == 8'h00);
  assign push     = push_req & ~full;
  assign drop     = push_req & full;
  assign pop      = tx_valid & tx_ready;

  assign status = {8'h00, 4'(count_q), 2'b00, full, empty};

  always_comb begin
    rd_mux = 16'h0000;
    case (off)
      8'h01:   rd_mux = status;
      8'h02:   rd_mux = timer_q;
      8'h03:   rd_mux = drops_q;
      default: rd_mux = 16'h0000;
    endcase
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    timer_d    = timer_q + 16'd1;
    drops_d    = drops_q;
    hit_r_d    = hit;
    mmio_q_r_d = rd_mux;

    if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A load replaces the increment for that cycle.
    if (wr_hit && off == 8'h02) timer_d = dp_data;

    if (wr_hit && off == 8'h03)          drops_d = 16'h0000;
    else if (drop && drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= 16'h0000;
      drops_q    <= 16'h0000;
      hit_r_q    <= 1'b0;
      mmio_q_r_q <= 16'h0000;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      drops_q    <= drops_d;
      hit_r_q    <= hit_r_d;
      mmio_q_r_q <= mmio_q_r_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= dp_data[7:0];
  end

  // Registered select keeps MMIO reads aligned with the RAM's read latency.
  assign dp_q = hit_r_q ? mmio_q_r_q : ram_q;

endmodule

// File: tb/tb_crp16_mmio_bridge.sv
module tb_crp16_mmio_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] dp_address;
  logic [15:0] dp_data;
  logic        dp_wren;
  logic [15:0] dp_q;
  logic [15:0] ram_address;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic [15:0] ram_q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  crp16_mmio_bridge #(
    .MMIO_BASE (16'hFF00),
    .FIFO_DEPTH(8),
    .FIFO_AW   (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dp_address (dp_address),
    .dp_data    (dp_data),
    .dp_wren    (dp_wren),
    .dp_q       (dp_q),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM model for port B.
  logic [15:0] ram_mem [65536];
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_mem[ram_address];
  end

  // Window writes must never reach the RAM.
  always @(negedge clock) begin
    if (ram_wren === 1'b1 && ram_address[15:8] == 8'hFF) viol++;
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        wren;
    logic [15:0] exp_q;
    logic        exp_txv;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] a, input logic [15:0] d, input logic w,
                     input logic [15:0] q, input logic v, input logic [7:0] t);
    vec_t x;
    x.addr = a; x.data = d; x.wren = w; x.exp_q = q; x.exp_txv = v; x.exp_txd = t;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w);
    dp_address = a;
    dp_data    = d;
    dp_wren    = w;
  endtask

  // Advance one edge and settle just after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram_mem[i] = 16'h0000;
    reset    = 1'b1;
    tx_ready = 1'b0;
    drive(16'hFF02, 16'h0000, 1'b0);
    cyc(); cyc();
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_dp_q_is_ram", dp_q, ram_q);

    // First edge after release samples TIMER = 0.
    reset = 1'b0;
    cyc();
    chk("timer_first_edge", dp_q, 16'h0000);

    // Table: passthrough, FIFO fill, drop, ignored writes, unmapped offsets.
    add(16'h0010, 16'h1234, 1'b1, 16'h0000, 1'b0, 8'h00);
    add(16'h0010, 16'h0000, 1'b0, 16'h1234, 1'b0, 8'h00);
    add(16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00);
    add(16'hFF01, 16'h0000, 1'b0, 16'h0001, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      add(16'hFF00, 16'h0041 + 16'(i), 1'b1, 16'h0000, 1'b1, 8'h41);
    add(16'hFF01, 16'h0000, 1'b0, 16'h0082, 1'b1, 8'h41);
    add(16'hFF00, 16'h0049, 1'b1, 16'h0000, 1'b1, 8'h41);
    add(16'hFF03, 16'h0000, 1'b0, 16'h0001, 1'b1, 8'h41);
    add(16'hFF01, 16'hFFFF, 1'b1, 16'h0082, 1'b1, 8'h41);
    add(16'hFF01, 16'h0000, 1'b0, 16'h0082, 1'b1, 8'h41);
    add(16'hFF10, 16'hBEEF, 1'b1, 16'h0000, 1'b1, 8'h41);
    add(16'hFF10, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h41);
    add(16'hFF80, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h41);
    add(16'hFEFF, 16'hABCD, 1'b1, 16'h0000, 1'b1, 8'h41);
    add(16'hFEFF, 16'h0000, 1'b0, 16'hABCD, 1'b1, 8'h41);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].addr, vecs[i].data, vecs[i].wren);
      cyc();
      chk($sformatf("vec%0d_dp_q", i), dp_q, vecs[i].exp_q);
      chk($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].exp_txv);
      if (vecs[i].exp_txv) chk($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].exp_txd);
    end

    // Drain in order.
    drive(16'h0010, 16'h0000, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), tx_valid, 1'b1);
      chk($sformatf("drain%0d_data", i), tx_data, 8'h41 + 8'(i));
      cyc();
    end
    chk("drained_valid", tx_valid, 1'b0);
    drive(16'hFF01, 16'h0000, 1'b0);
    cyc();
    chk("drained_status", dp_q, 16'h0001);
    cyc();
    chk("empty_ready_ignored", dp_q, 16'h0001);

    // Full FIFO with a simultaneous pop: push is still dropped.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(16'hFF00, 16'h0050 + 16'(i), 1'b1);
      cyc();
    end
    drive(16'hFF00, 16'h0055, 1'b1);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    drive(16'hFF01, 16'h0000, 1'b0);
    chk("fullpop_head", tx_data, 8'h51);
    cyc();
    chk("fullpop_status", dp_q, 16'h0070);
    drive(16'hFF03, 16'h0000, 1'b0);
    cyc();
    chk("fullpop_drops", dp_q, 16'h0002);

    // Timer load, read-during-write and wrap.
    drive(16'hFF02, 16'h1000, 1'b1);
    cyc();
    drive(16'hFF02, 16'hFFFE, 1'b1);
    cyc();
    chk("timer_rdw_old", dp_q, 16'h1000);
    drive(16'hFF02, 16'h0000, 1'b0);
    cyc();
    chk("timer_fffe", dp_q, 16'hFFFE);
    cyc();
    chk("timer_ffff", dp_q, 16'hFFFF);
    cyc();
    chk("timer_wrap", dp_q, 16'h0000);
    cyc();
    chk("timer_0001", dp_q, 16'h0001);

    // DROPS saturation and clear.
    drive(16'hFF00, 16'h0058, 1'b1);
    cyc();
    drive(16'hFF00, 16'h00EE, 1'b1);
    repeat (65540) @(posedge clock);
    #1;
    drive(16'hFF03, 16'h0000, 1'b0);
    cyc();
    chk("drops_saturated", dp_q, 16'hFFFF);
    drive(16'hFF03, 16'h5A5A, 1'b1);
    cyc();
    chk("drops_clear_rdw", dp_q, 16'hFFFF);
    drive(16'hFF03, 16'h0000, 1'b0);
    cyc();
    chk("drops_cleared", dp_q, 16'h0000);
    drive(16'hFF01, 16'h0000, 1'b0);
    cyc();
    chk("sat_status_full", dp_q, 16'h0082);

    // Reset with three entries queued.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    drive(16'hFF00, 16'h0061, 1'b1); cyc();
    drive(16'hFF00, 16'h0062, 1'b1); cyc();
    drive(16'hFF00, 16'h0063, 1'b1); cyc();
    chk("q3_valid", tx_valid, 1'b1);
    chk("q3_head", tx_data, 8'h61);
    drive(16'hFF02, 16'h0000, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", tx_valid, 1'b0);
    chk("async_rst_dp_q", dp_q, ram_q);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("post_rst_timer", dp_q, 16'h0000);
    drive(16'hFF01, 16'h0000, 1'b0);
    cyc();
    chk("post_rst_status", dp_q, 16'h0001);
    drive(16'hFF03, 16'h0000, 1'b0);
    cyc();
    chk("post_rst_drops", dp_q, 16'h0000);

    chk("ram_wren_in_window", viol, 0);
    chk("ram_window_untouched", ram_mem[16'hFF00], 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
